// File: rtl/rtc_bus_pkg.sv
// ============================================================================
//  Module      : rtc_bus_pkg
//  Description : Shared definitions for the RTC multiplexed-bus sequencers.
//                Holds the write-sequencer state encoding, the strobe hold
//                and inter-phase gap lengths, and the idle bus value.
//                The read-back states exist only when RTC_WR_VERIFY_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rtc_bus_pkg;

    localparam int                 TIMER_W  = 4;
    localparam logic [TIMER_W-1:0] HOLD_CYC = 4'd5;
    localparam logic [TIMER_W-1:0] GAP_CYC  = 4'd8;
    localparam logic [7:0]         BUS_IDLE = 8'hFF;

    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_WAIT_GNT = 5'd1,
        S_AD_LO    = 5'd2,
        S_CS_LO    = 5'd3,
        S_WR_LO    = 5'd4,
        S_DRV      = 5'd5,
        S_HOLD     = 5'd6,
        S_WR_HI    = 5'd7,
        S_CS_HI    = 5'd8,
        S_AD_HI    = 5'd9,
        S_GAP      = 5'd10,
        S_D_CS_LO  = 5'd11,
        S_D_WR_LO  = 5'd12,
        S_D_DRV    = 5'd13,
        S_D_HOLD   = 5'd14,
        S_D_WR_HI  = 5'd15,
        S_D_CS_HI  = 5'd16,
        S_REL      = 5'd17,
        S_DONE     = 5'd18
`ifdef RTC_WR_VERIFY_EN
        ,
        S_V_CS_LO  = 5'd19,
        S_V_RD_LO  = 5'd20,
        S_V_HOLD   = 5'd21,
        S_V_SAMPLE = 5'd22,
        S_V_RD_HI  = 5'd23,
        S_V_CS_HI  = 5'd24
`endif
    } rtc_state_t;

endpackage

`default_nettype wire

// File: rtl/rtc_hold_timer.sv
// ============================================================================
//  Module      : rtc_hold_timer
//  Description : Down-counter for the strobe hold and gap waits. Loading N-1
//                makes expired rise in the Nth cycle after the load.
//  Ports       : clock    - system clock
//                reset    - asynchronous active-low reset
//                load     - load load_val into the counter
//                load_val - wait length minus one
//                expired  - counter has reached zero
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rtc_hold_timer
    import rtc_bus_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expired
);

    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/rtc_wr_ctrl.sv
// ============================================================================
//  Module      : rtc_wr_ctrl
//  Description : Single-register write sequencer for an RTC on a multiplexed
//                address/data bus. Arbitrates for the bus, runs the address
//                phase, a gap, then the data phase, and pulses done.
//                Optional macro RTC_WR_VERIFY_EN appends a read-back of the
//                same register and flags a mismatch on err.
//  Ports       : clock, reset (async active-low)
//                start, wr_addr, wr_data   - write request
//                bus_req, bus_gnt          - arbiter handshake
//                ADin, ADout               - RTC bus in / out (idle 8'hFF)
//                ad, cs, wr, rd            - active-low RTC strobes
//                busy, done, err           - status
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rtc_wr_ctrl
    import rtc_bus_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       bus_req,
    input  logic       bus_gnt,
    input  logic [7:0] ADin,
    output logic [7:0] ADout,
    output logic       ad,
    output logic       cs,
    output logic       wr,
    output logic       rd,
    output logic       busy,
    output logic       done,
    output logic       err
);

    rtc_state_t         r_state, w_state_nxt;
    logic [7:0]         r_addr, r_data, r_adout, w_adout_nxt;
    logic               r_ad, r_cs, r_wr, r_rd, r_busy, r_done, r_err;
    logic               w_ad_nxt, w_cs_nxt, w_wr_nxt, w_rd_nxt, w_err_nxt;
    logic               w_accept, w_load, w_expired;
    logic [TIMER_W-1:0] w_load_val;

    assign w_accept = (r_state == S_IDLE) && start;

`ifdef RTC_WR_VERIFY_EN
    // Set once the write data phase is over; steers the second gap exit
    // into the read-back instead of another data phase.
    logic       r_vphase;
    logic [7:0] r_rdback;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vphase <= 1'b0;
            r_rdback <= '0;
        end else begin
            if (w_accept)
                r_vphase <= 1'b0;
            else if (r_state == S_REL)
                r_vphase <= 1'b1;
            if (r_state == S_V_SAMPLE)
                r_rdback <= ADin;
        end
    end
`else
    logic w_unused_adin;
    assign w_unused_adin = ^ADin;
`endif

    rtc_hold_timer u_hold_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state; the timer is loaded in the cycle before each wait state.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_WAIT_GNT;
            S_WAIT_GNT: if (bus_gnt) w_state_nxt = S_AD_LO;
            S_AD_LO:    w_state_nxt = S_CS_LO;
            S_CS_LO:    w_state_nxt = S_WR_LO;
            S_WR_LO:    w_state_nxt = S_DRV;
            S_DRV: begin
                w_state_nxt = S_HOLD;
                w_load      = 1'b1;
                w_load_val  = HOLD_CYC - 1'b1;
            end
            S_HOLD:     if (w_expired) w_state_nxt = S_WR_HI;
            S_WR_HI:    w_state_nxt = S_CS_HI;
            S_CS_HI:    w_state_nxt = S_AD_HI;
            S_AD_HI: begin
                w_state_nxt = S_GAP;
                w_load      = 1'b1;
                w_load_val  = GAP_CYC - 1'b1;
            end
            S_GAP: begin
                if (w_expired) begin
`ifdef RTC_WR_VERIFY_EN
                    w_state_nxt = r_vphase ? S_V_CS_LO : S_D_CS_LO;
`else
                    w_state_nxt = S_D_CS_LO;
`endif
                end
            end
            S_D_CS_LO:  w_state_nxt = S_D_WR_LO;
            S_D_WR_LO:  w_state_nxt = S_D_DRV;
            S_D_DRV: begin
                w_state_nxt = S_D_HOLD;
                w_load      = 1'b1;
                w_load_val  = HOLD_CYC - 1'b1;
            end
            S_D_HOLD:   if (w_expired) w_state_nxt = S_D_WR_HI;
            S_D_WR_HI:  w_state_nxt = S_D_CS_HI;
            S_D_CS_HI:  w_state_nxt = S_REL;
`ifdef RTC_WR_VERIFY_EN
            S_REL:      w_state_nxt = S_AD_LO;
            S_V_CS_LO:  w_state_nxt = S_V_RD_LO;
            S_V_RD_LO: begin
                w_state_nxt = S_V_HOLD;
                w_load      = 1'b1;
                w_load_val  = HOLD_CYC - 1'b1;
            end
            S_V_HOLD:   if (w_expired) w_state_nxt = S_V_SAMPLE;
            S_V_SAMPLE: w_state_nxt = S_V_RD_HI;
            S_V_RD_HI:  w_state_nxt = S_V_CS_HI;
            S_V_CS_HI:  w_state_nxt = S_DONE;
`else
            S_REL:      w_state_nxt = S_DONE;
`endif
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so each
    // strobe changes exactly on the edge that enters its state.
    always_comb begin
        w_adout_nxt = BUS_IDLE;
        w_ad_nxt    = 1'b1;
        w_cs_nxt    = 1'b1;
        w_wr_nxt    = 1'b1;
        w_rd_nxt    = 1'b1;
        case (w_state_nxt)
            S_AD_LO:    w_ad_nxt = 1'b0;
            S_CS_LO:    begin w_ad_nxt = 1'b0; w_cs_nxt = 1'b0; end
            S_WR_LO:    begin w_ad_nxt = 1'b0; w_cs_nxt = 1'b0; w_wr_nxt = 1'b0; end
            S_DRV, S_HOLD: begin
                w_ad_nxt = 1'b0; w_cs_nxt = 1'b0; w_wr_nxt = 1'b0;
                w_adout_nxt = r_addr;
            end
            S_WR_HI:    begin w_ad_nxt = 1'b0; w_cs_nxt = 1'b0; w_adout_nxt = r_addr; end
            S_CS_HI:    w_ad_nxt = 1'b0;
            S_D_CS_LO:  w_cs_nxt = 1'b0;
            S_D_WR_LO:  begin w_cs_nxt = 1'b0; w_wr_nxt = 1'b0; end
            S_D_DRV, S_D_HOLD: begin
                w_cs_nxt = 1'b0; w_wr_nxt = 1'b0;
                w_adout_nxt = r_data;
            end
            S_D_WR_HI:  begin w_cs_nxt = 1'b0; w_adout_nxt = r_data; end
`ifdef RTC_WR_VERIFY_EN
            S_V_CS_LO, S_V_RD_HI:            w_cs_nxt = 1'b0;
            S_V_RD_LO, S_V_HOLD, S_V_SAMPLE: begin w_cs_nxt = 1'b0; w_rd_nxt = 1'b0; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_err_nxt = r_err;
        if (w_accept)
            w_err_nxt = 1'b0;
`ifdef RTC_WR_VERIFY_EN
        // Compared on the edge into DONE so err is valid alongside done.
        if (r_state == S_V_CS_HI)
            w_err_nxt = (r_rdback != r_data);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_adout <= BUS_IDLE;
            r_ad    <= 1'b1;
            r_cs    <= 1'b1;
            r_wr    <= 1'b1;
            r_rd    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= wr_addr;
                r_data <= wr_data;
            end
            r_adout <= w_adout_nxt;
            r_ad    <= w_ad_nxt;
            r_cs    <= w_cs_nxt;
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            r_err   <= w_err_nxt;
        end
    end

    assign ADout   = r_adout;
    assign ad      = r_ad;
    assign cs      = r_cs;
    assign wr      = r_wr;
    assign rd      = r_rd;
    assign busy    = r_busy;
    assign bus_req = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rtc_wr_ctrl.sv
// ============================================================================
//  Module      : tb_rtc_wr_ctrl
//  Description : Directed self-checking bench for rtc_wr_ctrl. Cycle k=0 is
//                the WAIT_GNT cycle in which bus_gnt is high; the address
//                phase starts at k=1, REL is k=31 and done pulses at k=32.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rtc_wr_ctrl;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic       bus_gnt = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] ADin    = 8'h00;
    logic [7:0] ADout;
    logic       bus_req, ad, cs, wr, rd, busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    rtc_wr_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .bus_req (bus_req),
        .bus_gnt (bus_gnt),
        .ADin    (ADin),
        .ADout   (ADout),
        .ad      (ad),
        .cs      (cs),
        .wr      (wr),
        .rd      (rd),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {ADout, ad, cs, wr, rd, bus_req, busy, done}
    function automatic logic [14:0] cur_bus();
        return {ADout, ad, cs, wr, rd, bus_req, busy, done};
    endfunction

    // Expected bus picture for a plain write, indexed from the grant cycle.
    function automatic logic [14:0] exp_bus(input int k, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] o;
        logic       e_ad, e_cs, e_wr, e_busy, e_done;
        o = 8'hFF; e_ad = 1'b1; e_cs = 1'b1; e_wr = 1'b1; e_busy = 1'b1; e_done = 1'b0;
        if (k >= 1 && k <= 11)                         e_ad = 1'b0;
        if ((k >= 2 && k <= 10) || (k >= 21 && k <= 29)) e_cs = 1'b0;
        if ((k >= 3 && k <= 9)  || (k >= 22 && k <= 28)) e_wr = 1'b0;
        if (k >= 4 && k <= 10)                         o = a;
        if (k >= 23 && k <= 29)                        o = d;
        if (k == 32)                                   e_done = 1'b1;
        if (k >= 33)                                   e_busy = 1'b0;
        return {o, e_ad, e_cs, e_wr, 1'b1, e_busy, e_busy, e_done};
    endfunction

    // Status/strobe snapshot: {ADout, ad, cs, wr, rd, busy, bus_req, done, err}
    function automatic logic [15:0] status();
        return {ADout, ad, cs, wr, rd, busy, bus_req, done, err};
    endfunction

    // Bus rule monitor: never wr and rd low together; cs low only inside a transaction.
    always @(negedge clock) begin
        if (reset) begin
            check("wr_rd_overlap", {31'b0, (wr | rd)}, 32'd1);
            check("cs_outside_phase", {31'b0, (!cs && !busy)}, 32'd0);
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of k=0.
    task automatic do_start(input logic [7:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
    endtask

    // Compare the bus for k=0..last_k; optionally fire a stray start at inj_k.
    task automatic run_trace(input logic [7:0] a, input logic [7:0] d,
                             input int last_k, input int inj_k);
        for (int k = 0; k <= last_k; k++) begin
            if (k == inj_k + 1) start = 1'b0;
            check($sformatf("trace_k%0d", k), {17'b0, cur_bus()}, {17'b0, exp_bus(k, a, d)});
            if (k == inj_k) begin
                start   = 1'b1;
                wr_addr = 8'h24;
                wr_data = 8'h77;
            end
            if (k < last_k) @(negedge clock);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clock);
        check("reset_state", {16'b0, status()}, 32'h0000_FFF0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_after_release", {16'b0, status()}, 32'h0000_FFF0);

`ifndef RTC_WR_VERIFY_EN
        // Basic write with grant already present.
        bus_gnt = 1'b1;
        do_start(8'h23, 8'h11);
        run_trace(8'h23, 8'h11, 34, -1);
        check("t1_err", {31'b0, err}, 32'd0);

        // Grant withheld for 10 cycles.
        @(negedge clock);
        bus_gnt = 1'b0;
        do_start(8'h5A, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("gnt_wait_%0d", i), {20'b0, ADout, ad, cs, wr, rd},
                  {20'b0, 8'hFF, 4'b1111});
            check($sformatf("gnt_wait_req_%0d", i), {31'b0, bus_req}, 32'd1);
            @(negedge clock);
        end
        bus_gnt = 1'b1;
        run_trace(8'h5A, 8'hA5, 34, -1);

        // Stray start with addr 8'h24 during the address hold.
        @(negedge clock);
        do_start(8'h42, 8'h99);
        run_trace(8'h42, 8'h99, 34, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("no_second_txn_%0d", i), {31'b0, busy}, 32'd0);
        end

        // Reset during the data hold.
        do_start(8'h31, 8'h32);
        run_trace(8'h31, 8'h32, 25, -1);
        reset = 1'b0;
        #1;
        check("abort_immediate", {16'b0, status()}, 32'h0000_FFF0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("abort_no_done_%0d", i), {16'b0, status()}, 32'h0000_FFF0);
        end
        reset = 1'b1;
        @(negedge clock);
        check("after_abort_idle", {16'b0, status()}, 32'h0000_FFF0);
        do_start(8'h25, 8'h30);
        run_trace(8'h25, 8'h30, 34, -1);
`else
        // Read-back matches.
        bus_gnt = 1'b1;
        ADin    = 8'h11;
        do_start(8'h23, 8'h11);
        wait_done(lat);
        check("v_match_latency", lat, 32'd62);
        check("v_match_err", {31'b0, err}, 32'd0);

        // Read-back differs.
        @(negedge clock);
        ADin = 8'h10;
        do_start(8'h23, 8'h11);
        wait_done(lat);
        check("v_mismatch_latency", lat, 32'd62);
        check("v_mismatch_err", {31'b0, err}, 32'd1);
        repeat (3) @(negedge clock);
        check("v_err_sticky", {31'b0, err}, 32'd1);

        // New start clears err.
        ADin = 8'h5C;
        do_start(8'h44, 8'h5C);
        check("v_err_cleared", {31'b0, err}, 32'd0);
        wait_done(lat);
        check("v_third_latency", lat, 32'd62);
        check("v_third_err", {31'b0, err}, 32'd0);
`endif

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
